// File: rtl/vga_frame_reader.sv
// vga_frame_reader
//   Display-side reader for the QVGA RGB332 frame buffer. Generates VGA
//   timing from the pixel clock, reads the buffer's read-only port with 2x
//   upscaling in both axes and drives RGB444 to the connector. A colour-bar
//   pattern can replace buffer data for bring-up.
//
// Ports
//   Clk          in   pixel clock, rising edge
//   Rst          in   asynchronous active-high reset
//   data_out     in   [7:0]  buffer read data RGB332, valid one Clk after addr_out
//   Pattern      in   1 = colour bars, 0 = buffer image (sampled at frame start)
//   addr_out     out  [16:0] buffer read address
//   VGA_Hsync    out  horizontal sync, active low
//   VGA_Vsync    out  vertical sync, active low
//   VGA_R/G/B    out  [3:0] colour
//   Frame_start  out  one-Clk pulse when pixel (0,0) is on the pins
module vga_frame_reader #(
  parameter int H_VIS = 640,
  parameter int H_FP  = 16,
  parameter int H_SW  = 96,
  parameter int H_BP  = 48,
  parameter int V_VIS = 480,
  parameter int V_FP  = 10,
  parameter int V_SW  = 2,
  parameter int V_BP  = 33,
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [7:0]  data_out,
  input  logic        Pattern,
  output logic [16:0] addr_out,
  output logic        VGA_Hsync,
  output logic        VGA_Vsync,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        Frame_start
);

  // The address arithmetic is a fixed y*320 shift-add, so the stored image
  // geometry must match it.
  if (IMG_W != 320 || IMG_W * 2 != H_VIS || IMG_H * 2 != V_VIS) begin : g_geom_check
    $error("vga_frame_reader: image geometry does not match display timing");
  end

  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_ACT  = 10'(H_VIS);
  localparam logic [9:0] V_ACT  = 10'(V_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SW);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SW);

  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        pattern_q, pattern_d;
  logic [16:0] addr_q, addr_d;

  // Stages 1 and 2 of the timing side-band; stage 3 is the output registers.
  logic [2:1]  act_q, hs_q, vs_q, fs_q;
  logic [2:0]  bar1_q, bar2_q;

  logic        hs_out_q, vs_out_q, fs_out_q;
  logic [11:0] rgb_q, rgb_d;

  logic        act0, hs0_n, vs0_n, fs0;
  logic [8:0]  img_x, img_y;

  // Raw timing from the counters.
  always_comb begin
    act0  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    hs0_n = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    vs0_n = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    fs0   = (hcnt_q == '0) && (vcnt_q == '0);
  end

  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
    end
  end

  // 2x upscale: y*320 + x as (y<<8)+(y<<6)+x; the address holds in blanking.
  always_comb begin
    img_x  = hcnt_q[9:1];
    img_y  = vcnt_q[9:1];
    addr_d = addr_q;
    if (act0) begin
      addr_d = 17'({img_y, 8'b0}) + 17'({img_y, 6'b0}) + 17'(img_x);
    end
  end

  // Pattern only changes at the frame origin so a frame is never mixed.
  always_comb begin
    pattern_d = fs0 ? Pattern : pattern_q;
  end

  // Colour stage: data_out belongs to the pixel now at stage 2.
  always_comb begin
    rgb_d = '0;
    if (act_q[2]) begin
      if (pattern_q) begin
        case (bar2_q)
          3'd0:    rgb_d = 12'hFFF;
          3'd1:    rgb_d = 12'hF00;
          3'd2:    rgb_d = 12'h0F0;
          3'd3:    rgb_d = 12'h00F;
          default: rgb_d = 12'h000;
        endcase
      end else begin
        rgb_d = {data_out[7:5], data_out[7],
                 data_out[4:2], data_out[4],
                 data_out[1:0], data_out[1:0]};
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      pattern_q <= 1'b0;
      addr_q    <= '0;
      act_q     <= '0;
      hs_q      <= '1;
      vs_q      <= '1;
      fs_q      <= '0;
      bar1_q    <= '0;
      bar2_q    <= '0;
      hs_out_q  <= 1'b1;
      vs_out_q  <= 1'b1;
      fs_out_q  <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      pattern_q <= pattern_d;
      addr_q    <= addr_d;
      act_q     <= {act_q[1], act0};
      hs_q      <= {hs_q[1], hs0_n};
      vs_q      <= {vs_q[1], vs0_n};
      fs_q      <= {fs_q[1], fs0};
      bar1_q    <= hcnt_q[9:7];
      bar2_q    <= bar1_q;
      hs_out_q  <= hs_q[2];
      vs_out_q  <= vs_q[2];
      fs_out_q  <= fs_q[2];
      rgb_q     <= rgb_d;
    end
  end

  assign addr_out    = addr_q;
  assign VGA_Hsync   = hs_out_q;
  assign VGA_Vsync   = vs_out_q;
  assign Frame_start = fs_out_q;
  assign VGA_R       = rgb_q[11:8];
  assign VGA_G       = rgb_q[7:4];
  assign VGA_B       = rgb_q[3:0];

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: full horizontal timing, shortened vertical
// timing (8 visible lines, 15 total) so several frames fit in a short run.
// Expected values are tagged with the clock edge count since reset release
// and checked by a monitor at the falling edge.
module tb_vga_frame_reader;

  localparam int K_ADDR = 0;
  localparam int K_RGB  = 1;
  localparam int K_HS   = 2;
  localparam int K_VS   = 3;
  localparam int K_FS   = 4;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [7:0]  data_out = 8'h00;
  logic        Pattern = 1'b0;
  logic [16:0] addr_out;
  logic        VGA_Hsync, VGA_Vsync, Frame_start;
  logic [3:0]  VGA_R, VGA_G, VGA_B;

  exp_t q[$];
  int   cyc;
  int   checks = 0;
  int   passes = 0;
  int   fs_cnt = 0;
  int   max_addr = 0;
  string kname[5] = '{"addr", "rgb", "hsync", "vsync", "frame_start"};

  vga_frame_reader #(
    .H_VIS(640), .H_FP(16), .H_SW(96), .H_BP(48),
    .V_VIS(8),   .V_FP(2),  .V_SW(2),  .V_BP(3),
    .IMG_W(320), .IMG_H(4)
  ) dut (
    .Clk(Clk), .Rst(Rst), .data_out(data_out), .Pattern(Pattern),
    .addr_out(addr_out), .VGA_Hsync(VGA_Hsync), .VGA_Vsync(VGA_Vsync),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .Frame_start(Frame_start)
  );

  always #20 Clk = ~Clk;

  // Synchronous RAM model: contents equal the low address byte.
  always @(posedge Clk) data_out <= addr_out[7:0];

  always @(posedge Clk or posedge Rst) begin
    if (Rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic push(input int c, input int k, input int v);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v;
    q.push_back(e);
  endtask

  function automatic int actual(input int k);
    case (k)
      K_ADDR:  return int'(addr_out);
      K_RGB:   return int'({VGA_R, VGA_G, VGA_B});
      K_HS:    return int'(VGA_Hsync);
      K_VS:    return int'(VGA_Vsync);
      default: return int'(Frame_start);
    endcase
  endfunction

  // Monitor
  initial begin
    exp_t e;
    int   a;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        if (Frame_start) fs_cnt++;
        if (int'(addr_out) > max_addr) max_addr = int'(addr_out);
      end
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc != cyc) begin
          $display("FAIL %s@%0d: check missed (now cycle %0d), required %0h",
                   kname[e.kind], e.cyc, cyc, e.val);
        end else begin
          a = actual(e.kind);
          if (a == e.val) passes++;
          else $display("FAIL %s@%0d: got %0h, required %0h",
                        kname[e.kind], e.cyc, a, e.val);
        end
      end
    end
  end

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Phase 1: reset values, addressing, colour, sync, pattern switch.
    push(0, K_ADDR, 0); push(0, K_RGB, 0); push(0, K_HS, 1);
    push(0, K_VS, 1);   push(0, K_FS, 0);
    push(1, K_ADDR, 0);
    push(2, K_ADDR, 0); push(2, K_FS, 0);
    push(3, K_ADDR, 1); push(3, K_FS, 1);
    push(4, K_FS, 0);
    push(5, K_RGB, 'h005);
    push(451, K_RGB, 'hF00);
    push(513, K_RGB, 'hFFF);
    push(640, K_ADDR, 319);
    push(658, K_HS, 1);
    push(659, K_HS, 0);
    push(700, K_ADDR, 319);
    push(703, K_RGB, 'h000);
    push(754, K_HS, 0);
    push(755, K_HS, 1);
    push(803, K_RGB, 'h000);
    push(1601, K_ADDR, 320);
    push(1803, K_RGB, 'hB20);
    push(5703, K_RGB, 'hF9A);
    push(6240, K_ADDR, 1279);
    push(7303, K_RGB, 'h000);
    push(8002, K_VS, 1);
    push(8003, K_VS, 0);
    push(9602, K_VS, 0);
    push(9603, K_VS, 1);
    push(12002, K_FS, 0); push(12002, K_RGB, 'h000);
    push(12003, K_FS, 1); push(12003, K_RGB, 'hFFF);
    push(12130, K_RGB, 'hFFF);
    push(12131, K_RGB, 'hF00);
    push(12259, K_RGB, 'h0F0);
    push(12387, K_RGB, 'h00F);
    push(12515, K_RGB, 'h000);

    repeat (2) @(negedge Clk);
    @(posedge Clk);
    #2 Rst = 1'b0;

    while (cyc != 5000) @(negedge Clk);
    Pattern = 1'b1;

    while (cyc != 21500) @(negedge Clk);
    checks++;
    if (fs_cnt == 2) passes++;
    else $display("FAIL fs_count: got %0d pulses, required 2", fs_cnt);
    checks++;
    if (max_addr == 1279) passes++;
    else $display("FAIL max_addr: got %0d, required 1279", max_addr);

    // Phase 2: asynchronous reset in the sync region of line 11.
    @(posedge Clk);
    #1 Rst = 1'b1;
    push(0, K_ADDR, 0); push(0, K_RGB, 0); push(0, K_HS, 1);
    push(0, K_VS, 1);   push(0, K_FS, 0);
    push(2, K_FS, 0);
    push(3, K_FS, 1); push(3, K_ADDR, 1);
    push(5, K_RGB, 'h005);
    push(658, K_HS, 1);
    push(659, K_HS, 0);
    @(negedge Clk);
    #2;
    Pattern = 1'b0;
    Rst = 1'b0;

    while (cyc != 700) @(negedge Clk);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      $display("FAIL %s@%0d: never checked, required %0h", kname[e.kind], e.cyc, e.val);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
